div_serial: RTL and testbench
=============================

Name: div_serial

Overview:
- Sequential unsigned divider: 2W-bit dividend by W-bit divisor, yielding W-bit quotient and W-bit remainder.
- Inverse of the team's serial-parallel multiplier (`mult`); a product `o_c` fed back with one operand returns the other.
- Uses the same valid-in/valid-out operand interface as `mult`, plus an idle indicator.
- Restoring algorithm, one quotient bit per clock. Used both in datapath and as a hardware self-check of `mult` results.

Parameters:
- DATA_WIDTH, 32, divisor/quotient/remainder width; dividend is 2*DATA_WIDTH.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- i_n  input  2*DATA_WIDTH  dividend.
- i_d  input  DATA_WIDTH  divisor.
- i_valid  input  1  operands valid; sampled only when o_ready=1.
- o_ready  output  1  block idle, will accept i_valid this edge.
- o_valid  output  1  one-cycle pulse: o_q/o_r/o_ovf valid.
- o_q  output  DATA_WIDTH  quotient.
- o_r  output  DATA_WIDTH  remainder.
- o_ovf  output  1  divide-by-zero or quotient overflow.

Behaviour:
- Interface decision: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset (rst_n=0, immediate, no clock needed):
  - state=IDLE; o_ready=1; o_valid=0; o_q=0; o_r=0; o_ovf=0.
  - Internal shift/count registers cleared.
- Reset mid-operation: the operation is aborted, no o_valid is produced, and the block returns to IDLE.
- States: IDLE, RUN, DONE.
- IDLE:
  - o_ready=1.
  - On posedge with i_valid=1: capture i_n, i_d.
  - Overflow check uses the captured values: if i_d==0 or i_n[2W-1:W] >= i_d → DONE with ovf path, else → RUN.
  - Latch rem=i_n[2W-1:W], low=i_n[W-1:0], cnt=0.
- RUN (o_ready=0), each cycle:
  - t = {rem, low[W-1]} (W+1 bits).
  - If t >= {1'b0,i_d}: rem=t-i_d, qbit=1; else rem=t[W-1:0], qbit=0.
  - low shifts left, qbit enters low[0] (low reused as quotient register).
  - cnt increments; after exactly DATA_WIDTH RUN cycles → DONE.
- DONE (o_ready=0):
  - o_valid=1 for exactly one cycle, then → IDLE.
  - Normal path: o_q=low, o_r=rem, o_ovf=0.
  - Ovf path: o_q=all ones, o_r=0, o_ovf=1.
- o_q/o_r/o_ovf hold their last values after o_valid drops, until the next DONE.
- Latency, counting accepting edge as edge 0:
  - Normal path: o_valid seen high after edge DATA_WIDTH+1, i.e. DATA_WIDTH+2 clocks between accepts when back-to-back.
  - Ovf path: o_valid high after edge 1.
- i_valid while o_ready=0 is ignored (no queuing, no corruption). i_n/i_d may change freely after acceptance.
- Earliest next accept is the edge at which DONE→IDLE occurs plus one, i.e. when o_ready is seen high.
- Arithmetic: unsigned only. Invariant for non-ovf results: o_q*i_d + o_r == i_n and o_r < i_d.
- Registers of width W+1 are required for t; no wider arithmetic.

Test Plan:
- Reset then i_n=0, i_d=1 → after DATA_WIDTH+2 edges o_valid=1, o_q=0, o_r=0, o_ovf=0; o_valid low next cycle.
- i_n=8550, i_d=25 (product of `mult` test 342*25) → o_q=342, o_r=0. Then i_n=8567, i_d=25 → o_q=342, o_r=17.
- Boundary values:
  - i_n=64'hFFFFFFFE_00000001, i_d=32'hFFFFFFFF → o_q=32'hFFFFFFFF, o_r=0, o_ovf=0.
  - i_n=64'h1_00000000, i_d=1 → o_ovf=1, o_q=32'hFFFFFFFF, o_r=0, o_valid one edge after accept.
- i_d=0, i_n=5 → o_ovf=1, o_valid after 1 cycle, o_ready back high the following cycle.
- Second i_valid (i_n=100, i_d=7) during RUN → ignored; first result unaffected; exactly one o_valid. Re-issue when o_ready=1 → o_q=14, o_r=2.
- Assert rst_n=0 mid-RUN for half a cycle (asynchronous, not clock aligned) → outputs zero immediately, o_ready=1, no o_valid. A subsequent 8550/25 returns 342/0.
- Randomised check: 1000 random (a,b), b≠0, with i_n=a*b+r, r<b → o_q=a, o_r=r, o_ovf=0.

Source files
------------

// File: rtl/div_serial.sv
// div_serial: sequential unsigned restoring divider, one quotient bit per clock.
//   Divides a 2*DATA_WIDTH-bit dividend by a DATA_WIDTH-bit divisor.
// Ports:
//   clk      - clock, rising edge
//   rst_n    - asynchronous active-low reset
//   i_n      - dividend (2*DATA_WIDTH)
//   i_d      - divisor (DATA_WIDTH)
//   i_valid  - operands valid, sampled only while o_ready=1
//   o_ready  - idle, accepts i_valid at this edge
//   o_valid  - one-cycle pulse, o_q/o_r/o_ovf valid
//   o_q      - quotient (all ones on overflow)
//   o_r      - remainder (zero on overflow)
//   o_ovf    - divide-by-zero or quotient overflow
module div_serial #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [2*DATA_WIDTH-1:0] i_n,
    input  logic [DATA_WIDTH-1:0]   i_d,
    input  logic                    i_valid,
    output logic                    o_ready,
    output logic                    o_valid,
    output logic [DATA_WIDTH-1:0]   o_q,
    output logic [DATA_WIDTH-1:0]   o_r,
    output logic                    o_ovf
);

    localparam int unsigned W  = DATA_WIDTH;
    localparam int unsigned CW = $clog2(W + 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t          state_q, state_d;
    logic [W-1:0]    rem_q, rem_d;
    logic [W-1:0]    low_q, low_d;
    logic [W-1:0]    div_q, div_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            ovf_path_q, ovf_path_d;
    logic [W-1:0]    quot_q, quot_d;
    logic [W-1:0]    remr_q, remr_d;
    logic            ovf_q, ovf_d;
    logic            valid_q, valid_d;

    logic [W:0]      t;
    logic [W-1:0]    diff;
    logic            ge;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rem_q      <= '0;
            low_q      <= '0;
            div_q      <= '0;
            cnt_q      <= '0;
            ovf_path_q <= 1'b0;
            quot_q     <= '0;
            remr_q     <= '0;
            ovf_q      <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            low_q      <= low_d;
            div_q      <= div_d;
            cnt_q      <= cnt_d;
            ovf_path_q <= ovf_path_d;
            quot_q     <= quot_d;
            remr_q     <= remr_d;
            ovf_q      <= ovf_d;
            valid_q    <= valid_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        low_d      = low_q;
        div_d      = div_q;
        cnt_d      = cnt_q;
        ovf_path_d = ovf_path_q;
        quot_d     = quot_q;
        remr_d     = remr_q;
        ovf_d      = ovf_q;
        valid_d    = 1'b0;

        t    = {rem_q, low_q[W-1]};
        ge   = (t >= {1'b0, div_q});
        // When ge holds the difference is below the divisor, so W bits suffice.
        diff = t[W-1:0] - div_q;

        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    div_d      = i_d;
                    rem_d      = i_n[2*W-1:W];
                    low_d      = i_n[W-1:0];
                    cnt_d      = '0;
                    ovf_path_d = (i_d == '0) || (i_n[2*W-1:W] >= i_d);
                    state_d    = ovf_path_d ? DONE : RUN;
                end
            end
            RUN: begin
                rem_d = ge ? diff : t[W-1:0];
                // low doubles as the quotient register: bits shift out the top
                // into the partial remainder while quotient bits enter at bit 0.
                low_d = {low_q[W-2:0], ge};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(W - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                valid_d = 1'b1;
                state_d = IDLE;
                if (ovf_path_q) begin
                    quot_d = '1;
                    remr_d = '0;
                    ovf_d  = 1'b1;
                end else begin
                    quot_d = low_q;
                    remr_d = rem_q;
                    ovf_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign o_ready = (state_q == IDLE);
    assign o_valid = valid_q;
    assign o_q     = quot_q;
    assign o_r     = remr_q;
    assign o_ovf   = ovf_q;

endmodule

// File: tb/tb_div_serial.sv
// tb_div_serial: directed and randomised self-checking bench for div_serial.
module tb_div_serial;

    localparam int unsigned W = 32;

    logic           clk;
    logic           rst_n;
    logic [2*W-1:0] i_n;
    logic [W-1:0]   i_d;
    logic           i_valid;
    logic           o_ready;
    logic           o_valid;
    logic [W-1:0]   o_q;
    logic [W-1:0]   o_r;
    logic           o_ovf;

    int total;
    int bad;

    div_serial #(.DATA_WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_n     (i_n),
        .i_d     (i_d),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .o_valid (o_valid),
        .o_q     (o_q),
        .o_r     (o_r),
        .o_ovf   (o_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Called at posedge+1; waits for o_ready, presents operands for one edge.
    task automatic start(input string tag, input logic [2*W-1:0] n, input logic [W-1:0] d);
        int waited;
        waited = 0;
        while (!o_ready && waited < 100) begin
            @(posedge clk);
            #1;
            waited++;
        end
        check({tag, "_ready"}, 64'(o_ready), 64'd1);
        i_n     = n;
        i_d     = d;
        i_valid = 1'b1;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
    endtask

    // Counts edges until o_valid, then checks result, latency and pulse width.
    task automatic wait_res(input string tag, input logic [W-1:0] eq, input logic [W-1:0] er,
                            input logic eovf, input int elat);
        int lat;
        lat = 0;
        for (int c = 1; c <= 100; c++) begin
            @(posedge clk);
            #1;
            if (o_valid) begin
                lat = c;
                break;
            end
        end
        check({tag, "_lat"}, 64'(lat), 64'(elat));
        check({tag, "_q"}, 64'(o_q), 64'(eq));
        check({tag, "_r"}, 64'(o_r), 64'(er));
        check({tag, "_ovf"}, 64'(o_ovf), 64'(eovf));
        check({tag, "_rdy"}, 64'(o_ready), 64'd1);
        @(posedge clk);
        #1;
        check({tag, "_pulse"}, 64'(o_valid), 64'd0);
        check({tag, "_hold"}, 64'(o_q), 64'(eq));
    endtask

    task automatic no_valid(input string tag, input int cycles);
        int seen;
        seen = 0;
        for (int c = 0; c < cycles; c++) begin
            @(posedge clk);
            #1;
            if (o_valid) seen++;
        end
        check({tag, "_novalid"}, 64'(seen), 64'd0);
    endtask

    initial begin
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [W-1:0]   r;
        logic [2*W-1:0] n;

        total   = 0;
        bad     = 0;
        rst_n   = 1'b0;
        i_n     = '0;
        i_d     = '0;
        i_valid = 1'b0;

        // Reset state before any clock edge.
        #2;
        check("rst_ready", 64'(o_ready), 64'd1);
        check("rst_valid", 64'(o_valid), 64'd0);
        check("rst_q", 64'(o_q), 64'd0);
        check("rst_r", 64'(o_r), 64'd0);
        check("rst_ovf", 64'(o_ovf), 64'd0);
        #10;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        start("zero", 64'd0, 32'd1);
        wait_res("zero", 32'd0, 32'd0, 1'b0, W + 1);

        start("exact", 64'd8550, 32'd25);
        wait_res("exact", 32'd342, 32'd0, 1'b0, W + 1);

        start("remain", 64'd8567, 32'd25);
        wait_res("remain", 32'd342, 32'd17, 1'b0, W + 1);

        start("maxq", 64'hFFFFFFFE_00000001, 32'hFFFFFFFF);
        wait_res("maxq", 32'hFFFFFFFF, 32'd0, 1'b0, W + 1);

        start("qovf", 64'h1_00000000, 32'd1);
        wait_res("qovf", 32'hFFFFFFFF, 32'd0, 1'b1, 1);

        start("dz", 64'd5, 32'd0);
        wait_res("dz", 32'hFFFFFFFF, 32'd0, 1'b1, 1);

        // Back-to-back after overflow: normal result clears o_ovf.
        start("after_ovf", 64'd8567, 32'd25);
        wait_res("after_ovf", 32'd342, 32'd17, 1'b0, W + 1);

        // A second request during RUN is ignored.
        start("busy", 64'd8550, 32'd25);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("busy_notready", 64'(o_ready), 64'd0);
        i_n     = 64'd100;
        i_d     = 32'd7;
        i_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
        end
        i_valid = 1'b0;
        wait_res("busy", 32'd342, 32'd0, 1'b0, W + 1 - 5);
        no_valid("busy", W + 4);
        start("reissue", 64'd100, 32'd7);
        wait_res("reissue", 32'd14, 32'd2, 1'b0, W + 1);

        // Asynchronous reset mid-RUN, not aligned to any clock edge.
        start("abort", 64'd8550, 32'd25);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_ready", 64'(o_ready), 64'd1);
        check("abort_valid", 64'(o_valid), 64'd0);
        check("abort_q", 64'(o_q), 64'd0);
        check("abort_r", 64'(o_r), 64'd0);
        check("abort_ovf", 64'(o_ovf), 64'd0);
        #4;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        no_valid("abort", W + 4);
        start("post_abort", 64'd8550, 32'd25);
        wait_res("post_abort", 32'd342, 32'd0, 1'b0, W + 1);

        // Randomised: n = a*b + r with r < b guarantees quotient a, remainder r.
        for (int i = 0; i < 1000; i++) begin
            a = $urandom;
            if (i % 3 == 0) b = W'($urandom_range(1, 255));
            else            b = $urandom;
            if (b == '0) b = 32'd1;
            r = $urandom % b;
            n = ({32'd0, a} * {32'd0, b}) + {32'd0, r};
            start("rand", n, b);
            wait_res("rand", a, r, 1'b0, W + 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so the bench always terminates.
    initial begin
        #5ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
